// File: rtl/piso_ctrl_pkg.sv
// Shared FSM state type and counter sizing for the PISO transmit controller.
// Defining PISO_PARITY_EN adds the PARITY state (even parity bit after the data bits).
package piso_ctrl_pkg;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit parallel-load, shift-right register with LSB serial output.
// Load takes priority over shift; both are synchronous.
module piso_shift_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] par_in,
  output logic         ser_out
);

  logic [N-1:0] r_q;

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)         r_q <= '0;
    else if (load)     r_q <= par_in;
    else if (shift_en) r_q <= r_q >> 1;
  end

  assign ser_out = r_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmit controller with valid/ready handshakes on both sides.
// Optional even-parity bit when PISO_PARITY_EN is defined.
module piso_tx_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         sout,
  output logic         sout_valid,
  input  logic         sout_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_sout_valid;
  logic          w_load;
  logic          w_xfer;
  logic          w_shift_en;
  logic          w_last_xfer;
  logic          w_ser;

  assign w_load     = r_in_ready && in_valid;
  assign w_xfer     = r_sout_valid && sout_ready;
  assign w_shift_en = w_xfer && (r_state == SHIFT);

  piso_shift_reg #(.N(N)) u_shift_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .shift_en (w_shift_en),
    .par_in   (in_data),
    .ser_out  (w_ser)
  );

`ifdef PISO_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (reset)       r_par <= 1'b0;
    else if (w_load) r_par <= ^in_data;
  end

  assign w_last_xfer = w_xfer && (r_state == PARITY);
`else
  assign w_last_xfer = w_xfer && (r_state == SHIFT) && (r_cnt == LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state      <= SHIFT;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b1;
            r_sout_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
`ifdef PISO_PARITY_EN
              r_state      <= PARITY;
`else
              r_state      <= IDLE;
              r_in_ready   <= 1'b1;
              r_busy       <= 1'b0;
              r_sout_valid <= 1'b0;
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (w_xfer) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_sout_valid <= 1'b0;
          end
        end
`endif
        default: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_busy       <= 1'b0;
          r_sout_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the default assignment first guarantees no latch on any path through the block.
  always_comb begin
    sout = 1'b0;
    if (r_sout_valid) sout = w_ser;
`ifdef PISO_PARITY_EN
    if (r_state == PARITY) sout = r_par;
`endif
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign sout_valid = r_sout_valid;
  // Gated by reset so an aborted frame never reports completion.
  assign frame_done = !reset && w_last_xfer;

endmodule

// File: doc/piso_tx_ctrl.md
PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, data word width in bits (N >= 1).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled only on rising clk.
REQ-004 SHALL have port in_data, input, N, parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1, in_data valid.
REQ-006 SHALL have port in_ready, output, 1, controller can accept a word.
REQ-007 SHALL have port sout, output, 1, serial data bit.
REQ-008 SHALL have port sout_valid, output, 1, sout carries a frame bit.
REQ-009 SHALL have port sout_ready, input, 1, sink accepts sout this cycle.
REQ-010 SHALL have port busy, output, 1, a frame is in progress.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse on the cycle the last frame bit is accepted.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY exists only with PARITY_EN.
REQ-013 SHALL, in IDLE, drive in_ready=1, busy=0, sout_valid=0 and sout=0.
REQ-014 SHALL accept a word when in_valid && in_ready, in cycle T: load in_data into the shift register, clear the bit counter, and enter SHIFT at T+1.
REQ-015 SHALL, in SHIFT, drive in_ready=0, busy=1, sout_valid=1, with sout = shift register LSB (LSB-first).
REQ-016 SHALL treat a bit as transferred only on cycles with sout_valid && sout_ready; on that edge the register shifts right one position and the counter increments.
REQ-017 SHALL hold sout, the register and the counter unchanged while sout_ready=0 (stall of any length).
REQ-018 SHALL, on transfer of bit N-1, assert frame_done in that cycle and return to IDLE (or enter PARITY if PARITY_EN).
REQ-019 SHALL give zero-stall latency: first bit at T+1, last data bit at T+N, in_ready=1 again at T+N+1 (one idle cycle between back-to-back frames).
REQ-020 SHALL ignore in_valid while busy=1; in_data changes after acceptance SHALL NOT affect the frame.
REQ-021 SHALL size the counter at $clog2(N+1) bits and SHALL work for N=1 (single-bit frame, frame_done at T+1).

Reset
REQ-022 SHALL, while reset=1, force IDLE, counter=0, register=0, in_ready=1 on the first cycle after release, busy=0, sout=0, sout_valid=0, frame_done=0.
REQ-023 SHALL abort a frame in progress on reset with no frame_done pulse; the partial frame is discarded.

Configuration
REQ-024 SHALL use macro PISO_PARITY_EN: when defined, the FSM enters PARITY after bit N-1, drives sout = XOR of the accepted word (even parity), sout_valid=1, obeys REQ-017 stalls, pulses frame_done on parity transfer (not on bit N-1), then returns to IDLE; frame length becomes N+1.
REQ-025 SHALL, without PISO_PARITY_EN, have no PARITY state or parity logic; frame length is N.

Structure
REQ-026 SHALL place the FSM state enum and a counter-width helper function in package piso_ctrl_pkg.
REQ-027 SHALL instantiate sub-module piso_shift_reg (N-bit, synchronous parallel load, shift-right enable, LSB serial out); the controller drives only load and shift_en.

Verification
REQ-028 SHALL verify N=8, in_data=0xA5, sout_ready=1: sout = 1,0,1,0,0,1,0,1 at T+1..T+8, frame_done at T+8 only, in_ready=1 at T+9.
REQ-029 SHALL verify stall: sout_ready=0 for 3 cycles after bit 2 -> sout holds bit 3 value for 4 cycles, frame_done at T+11.
REQ-030 SHALL verify back-to-back: 0x01 then 0xFF with in_valid held high -> second acceptance at T+9, bits 1,0,0,0,0,0,0,0 then eight 1s.
REQ-031 SHALL verify reset asserted at T+4 of a 0x3C frame -> next cycle IDLE, sout_valid=0, no frame_done; a subsequent 0x81 frame serializes correctly.
REQ-032 SHALL verify with PISO_PARITY_EN, in_data=0x07: eight data bits then parity bit 1 at T+9, frame_done at T+9 only; in_valid pulses during busy are ignored.
